// File: rtl/north_rdata_pkt_if.sv
// north_rdata_pkt_if: read-data and stream handshake bundle for north_rdata_pkt.
//   gdma_ddr_r*   : DDR read-data channel (rdata/rlast/rresp/rvalid in, rready out of the design)
//   gdma2gtp_t*   : outbound stream (tdata/tvalid/tlast out of the design, tready in)
// master: the packetiser side; slave: the environment (DDR read source + stream sink).
interface north_rdata_pkt_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] gdma_ddr_rdata;
  logic              gdma_ddr_rlast;
  logic [1:0]        gdma_ddr_rresp;
  logic              gdma_ddr_rvalid;
  logic              gdma_ddr_rready;
  logic [DATA_W-1:0] gdma2gtp_tdata;
  logic              gdma2gtp_tvalid;
  logic              gdma2gtp_tready;
  logic              gdma2gtp_tlast;

  modport master (
    input  gdma_ddr_rdata, gdma_ddr_rlast, gdma_ddr_rresp, gdma_ddr_rvalid,
    output gdma_ddr_rready,
    output gdma2gtp_tdata, gdma2gtp_tvalid, gdma2gtp_tlast,
    input  gdma2gtp_tready
  );

  modport slave (
    output gdma_ddr_rdata, gdma_ddr_rlast, gdma_ddr_rresp, gdma_ddr_rvalid,
    input  gdma_ddr_rready,
    input  gdma2gtp_tdata, gdma2gtp_tvalid, gdma2gtp_tlast,
    output gdma2gtp_tready
  );
endinterface

// File: rtl/north_rdata_pkt.sv
// north_rdata_pkt: forwards DDR read beats to a stream, either straight through
// (bypass) or packetised as [header, n payload beats] with a programmable gap.
// Ports:
//   clk, rst                  clock, async active-high reset
//   length, op_start          transfer size in bytes, one-cycle start pulse
//   gdma_addr_done            address side finished
//   gdma_done                 transfer complete / idle
//   gdma_speed_divider        inter-packet gap in cycles
//   gdma_package_bypass       bypass request (ORed with extern_spike, latched at start)
//   extern_spike              forces bypass
//   resp_err                  sticky read-error flag, cleared on op_start
//   bus                       read channel + stream (north_rdata_pkt_if.master)
module north_rdata_pkt #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int PKT_BEATS  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] length,
  input  logic        op_start,
  input  logic        gdma_addr_done,
  output logic        gdma_done,
  input  logic [31:0] gdma_speed_divider,
  input  logic        gdma_package_bypass,
  input  logic        extern_spike,
  output logic        resp_err,
  north_rdata_pkt_if.master bus
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int SHIFT = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {IDLE, HEAD, PAY, GAP} state_t;

  state_t            state_q;
  logic              byp_q, started_q;
  logic [31:0]       beats_q, acc_q, rem_q, gap_q;
  logic [23:0]       pay_left_q;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wp_q, rp_q, fifo_cnt;
  logic              fifo_full, fifo_empty, beyond, accept, take;
  logic              fifo_wr, fifo_rd, out_hs, all_acc, done_cond;
  logic [31:0]       acc_next;
  logic [23:0]       n_w;
  logic [DATA_W-1:0] hdr_w;
  logic              unused_rlast;

  assign unused_rlast = bus.gdma_ddr_rlast;

  assign fifo_cnt   = wp_q - rp_q;
  assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  assign beyond = (acc_q >= beats_q);
  assign bus.gdma_ddr_rready = byp_q ? bus.gdma2gtp_tready : (started_q & ~fifo_full);
  // op_start wins over a same-cycle beat: the beat is neither counted nor stored.
  assign accept  = bus.gdma_ddr_rvalid & bus.gdma_ddr_rready & ~op_start;
  assign take    = accept & ~beyond;
  assign fifo_wr = take & ~byp_q;
  assign out_hs  = bus.gdma2gtp_tvalid & bus.gdma2gtp_tready;
  assign fifo_rd = ~byp_q & (state_q == PAY) & out_hs & ~op_start;

  assign acc_next  = acc_q + {31'd0, take};
  assign all_acc   = (acc_next >= beats_q);
  assign done_cond = gdma_addr_done & all_acc &
                     (byp_q | (fifo_empty & (state_q == IDLE) & (rem_q == '0)));

  // rem_q is constant while in HEAD, so the header stays stable under backpressure.
  assign n_w = (rem_q > 32'(PKT_BEATS)) ? 24'(PKT_BEATS) : rem_q[23:0];

  always_comb begin
    hdr_w                 = '0;
    hdr_w[DATA_W-1 -: 8]  = 8'hA5;
    hdr_w[23:0]           = n_w;
  end

  always_comb begin
    bus.gdma2gtp_tdata  = '0;
    bus.gdma2gtp_tvalid = 1'b0;
    bus.gdma2gtp_tlast  = 1'b0;
    if (byp_q) begin
      bus.gdma2gtp_tdata  = bus.gdma_ddr_rdata;
      bus.gdma2gtp_tvalid = bus.gdma_ddr_rvalid & ~beyond;
    end else begin
      case (state_q)
        HEAD: begin
          bus.gdma2gtp_tdata  = hdr_w;
          bus.gdma2gtp_tvalid = 1'b1;
        end
        PAY: begin
          bus.gdma2gtp_tdata  = mem[rp_q[AW-1:0]];
          bus.gdma2gtp_tvalid = ~fifo_empty;
          bus.gdma2gtp_tlast  = (pay_left_q == 24'd1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wp_q[AW-1:0]] <= bus.gdma_ddr_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      byp_q      <= 1'b0;
      started_q  <= 1'b0;
      beats_q    <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      gap_q      <= '0;
      pay_left_q <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      gdma_done  <= 1'b1;
      resp_err   <= 1'b0;
    end else if (op_start) begin
      state_q    <= IDLE;
      byp_q      <= gdma_package_bypass | extern_spike;
      started_q  <= 1'b1;
      beats_q    <= length >> SHIFT;
      rem_q      <= length >> SHIFT;
      acc_q      <= '0;
      gap_q      <= '0;
      pay_left_q <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      gdma_done  <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      if (accept && bus.gdma_ddr_rresp != 2'b00) resp_err <= 1'b1;
      if (take)      acc_q     <= acc_next;
      if (fifo_wr)   wp_q      <= wp_q + 1'b1;
      if (fifo_rd)   rp_q      <= rp_q + 1'b1;
      if (done_cond) gdma_done <= 1'b1;
      // The IDLE check (data pending, FIFO non-empty) is folded into the PAY and
      // GAP exits so the header follows the gap with no extra idle cycle.
      case (state_q)
        IDLE: if (!byp_q && rem_q != '0 && !fifo_empty) state_q <= HEAD;
        HEAD: if (bus.gdma2gtp_tready) begin
          state_q    <= PAY;
          pay_left_q <= n_w;
        end
        PAY: if (fifo_rd) begin
          rem_q      <= rem_q - 1'b1;
          pay_left_q <= pay_left_q - 1'b1;
          if (pay_left_q == 24'd1) begin
            if (gdma_speed_divider != '0) begin
              state_q <= GAP;
              gap_q   <= gdma_speed_divider;
            end else if (rem_q > 32'd1 && (fifo_cnt > (AW+1)'(1) || fifo_wr)) begin
              state_q <= HEAD;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_q <= 32'd1) state_q <= (rem_q != '0 && !fifo_empty) ? HEAD : IDLE;
          else                gap_q   <= gap_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_north_rdata_pkt.sv
module tb_north_rdata_pkt;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] length;
  logic        op_start;
  logic        gdma_addr_done;
  logic        gdma_done;
  logic [31:0] gdma_speed_divider;
  logic        gdma_package_bypass;
  logic        extern_spike;
  logic        resp_err;

  always #5 clk = ~clk;

  north_rdata_pkt_if #(.DATA_W(32)) bus ();

  north_rdata_pkt #(.DATA_W(32), .FIFO_DEPTH(4), .PKT_BEATS(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .length             (length),
    .op_start           (op_start),
    .gdma_addr_done     (gdma_addr_done),
    .gdma_done          (gdma_done),
    .gdma_speed_divider (gdma_speed_divider),
    .gdma_package_bypass(gdma_package_bypass),
    .extern_spike       (extern_spike),
    .resp_err           (resp_err),
    .bus                (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [31:0] src_data[$];
  logic [1:0]  src_resp[$];
  int          src_idx;
  bit          src_acc;
  logic [31:0] exp_data[$];
  bit          exp_last[$];
  bit          exp_hdr[$];
  int          out_cyc[$];
  int          out_cnt, in_acc, pops, cyc;
  bit          sink_rand, chk_occ, chk_byp, op_pend, prev_stall, prev_op;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic tick();
    @(posedge clk);
    #1;
    if (src_acc) src_idx++;
    op_start = op_pend;
    op_pend  = 1'b0;
    bus.gdma_ddr_rvalid = !op_start && (src_idx < src_data.size());
    if (bus.gdma_ddr_rvalid) begin
      bus.gdma_ddr_rdata = src_data[src_idx];
      bus.gdma_ddr_rresp = src_resp[src_idx];
    end else begin
      bus.gdma_ddr_rdata = '0;
      bus.gdma_ddr_rresp = 2'b00;
    end
    bus.gdma2gtp_tready = sink_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    cyc++;
    if (prev_stall && !prev_op) begin
      check("hold_valid", bus.gdma2gtp_tvalid, 1);
      check("hold_data",  bus.gdma2gtp_tdata,  prev_data);
      check("hold_last",  bus.gdma2gtp_tlast,  prev_last);
    end
    if (chk_byp && bus.gdma_ddr_rvalid && src_idx < 4) begin
      check("byp_tvalid", bus.gdma2gtp_tvalid, 1);
      check("byp_tdata",  bus.gdma2gtp_tdata,  bus.gdma_ddr_rdata);
    end
    if (chk_occ && !op_start)
      check("rready_vs_fill", bus.gdma_ddr_rready, ((in_acc - pops) < 4) ? 1 : 0);
    src_acc = bus.gdma_ddr_rvalid & bus.gdma_ddr_rready;
    if (src_acc) in_acc++;
    if (bus.gdma2gtp_tvalid && bus.gdma2gtp_tready && !op_start) begin
      if (out_cnt < exp_data.size()) begin
        check($sformatf("out_data[%0d]", out_cnt), bus.gdma2gtp_tdata, exp_data[out_cnt]);
        check($sformatf("out_last[%0d]", out_cnt), bus.gdma2gtp_tlast, exp_last[out_cnt]);
        if (!exp_hdr[out_cnt]) pops++;
      end else begin
        check("extra_beat", out_cnt, exp_data.size());
      end
      out_cyc.push_back(cyc);
      out_cnt++;
    end
    prev_stall = bus.gdma2gtp_tvalid & ~bus.gdma2gtp_tready;
    prev_data  = bus.gdma2gtp_tdata;
    prev_last  = bus.gdma2gtp_tlast;
    prev_op    = op_start;
  endtask

  task automatic start_op(input logic [31:0] len, input bit byp);
    length              = len;
    gdma_package_bypass = byp;
    op_pend             = 1'b1;
    src_data.delete(); src_resp.delete();
    exp_data.delete(); exp_last.delete(); exp_hdr.delete(); out_cyc.delete();
    src_idx = 0; src_acc = 0; out_cnt = 0; in_acc = 0; pops = 0;
  endtask

  task automatic build_pkg(input int nb);
    int rem = nb;
    int idx = 0;
    while (rem > 0) begin
      int n = (rem > 4) ? 4 : rem;
      exp_data.push_back(32'hA500_0000 | 32'(n)); exp_last.push_back(0); exp_hdr.push_back(1);
      for (int j = 0; j < n; j++) begin
        exp_data.push_back(src_data[idx+j]); exp_last.push_back(j == n-1); exp_hdr.push_back(0);
      end
      idx += n;
      rem -= n;
    end
  endtask

  task automatic run_until_out(input string tag, input int n, input int bound);
    int i = 0;
    while (out_cnt < n && i < bound) begin
      tick();
      i++;
    end
    check(tag, out_cnt, n);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int i = 0;
    while (!gdma_done && i < bound) begin
      tick();
      i++;
    end
    check(tag, gdma_done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; length = '0; op_start = 1'b0; gdma_addr_done = 1'b0;
    gdma_speed_divider = '0; gdma_package_bypass = 1'b0; extern_spike = 1'b0;
    bus.gdma_ddr_rdata = '0; bus.gdma_ddr_rlast = 1'b0; bus.gdma_ddr_rresp = 2'b00;
    bus.gdma_ddr_rvalid = 1'b0; bus.gdma2gtp_tready = 1'b1;
    src_idx = 0; src_acc = 0; out_cnt = 0; in_acc = 0; pops = 0; cyc = 0;
    sink_rand = 0; chk_occ = 0; chk_byp = 0; op_pend = 0; prev_stall = 0; prev_op = 0;
    prev_data = '0; prev_last = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_done",   gdma_done, 1);
    check("rst_err",    resp_err, 0);
    check("rst_tvalid", bus.gdma2gtp_tvalid, 0);
    check("rst_tlast",  bus.gdma2gtp_tlast, 0);
    check("rst_rready", bus.gdma_ddr_rready, 0);
    rst = 1'b0;
    tick();
    check("idle_rready_pkg", bus.gdma_ddr_rready, 0);

    // Bypass: 16 bytes -> 4 beats, a 5th beat is accepted and dropped
    gdma_addr_done = 1'b1;
    start_op(32'd16, 1'b1);
    for (int i = 0; i < 5; i++) begin
      src_data.push_back(32'h1000_0001 + 32'(i)); src_resp.push_back(2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      exp_data.push_back(src_data[i]); exp_last.push_back(0); exp_hdr.push_back(0);
    end
    chk_byp = 1;
    tick();
    tick();
    check("byp_done_fall", gdma_done, 0);
    run_until_out("byp_count", 4, 20);
    check("byp_done_pre", gdma_done, 0);
    tick();
    check("byp_done", gdma_done, 1);
    check("byp_drop_tvalid", bus.gdma2gtp_tvalid, 0);
    check("byp_drop_rready", bus.gdma_ddr_rready, 1);
    tick();
    chk_byp = 0;

    // Package: 40 bytes -> headers 4,4,2 with a 5-cycle gap
    gdma_speed_divider = 32'd5;
    start_op(32'd40, 1'b0);
    for (int i = 0; i < 10; i++) begin
      src_data.push_back(32'hA0A0_0000 + 32'(i)); src_resp.push_back(2'b00);
    end
    build_pkg(10);
    tick();
    run_until_out("pkg_count", 13, 200);
    if (out_cyc.size() >= 11) begin
      check("gap1", out_cyc[5] - out_cyc[4] - 1, 5);
      check("gap2", out_cyc[10] - out_cyc[9] - 1, 5);
    end
    check("pkg_done_pre", gdma_done, 0);
    wait_done("pkg_done", 30);

    // Random backpressure with a 4-deep FIFO, back-to-back packets
    gdma_speed_divider = 32'd0;
    start_op(32'd48, 1'b0);
    for (int i = 0; i < 12; i++) begin
      src_data.push_back($urandom); src_resp.push_back(2'b00);
    end
    build_pkg(12);
    sink_rand = 1; chk_occ = 1;
    tick();
    run_until_out("rand_count", 15, 600);
    sink_rand = 0; chk_occ = 0;
    wait_done("rand_done", 30);

    // Read error on beat 3, then restart mid-packet
    start_op(32'd32, 1'b0);
    for (int i = 0; i < 8; i++) begin
      src_data.push_back(32'hE000_0000 + 32'(i)); src_resp.push_back(i == 2 ? 2'b10 : 2'b00);
    end
    build_pkg(8);
    tick();
    tick();
    check("err_clear_start", resp_err, 0);
    run_until_out("err_partial", 3, 50);
    check("err_set", resp_err, 1);
    start_op(32'd12, 1'b0);
    for (int i = 0; i < 3; i++) begin
      src_data.push_back(32'h5000_0000 + 32'(i)); src_resp.push_back(2'b00);
    end
    build_pkg(3);
    tick();
    tick();
    check("err_cleared", resp_err, 0);
    run_until_out("restart_count", 4, 100);
    wait_done("restart_done", 30);

    // Zero beats: remainder bytes ignored, done waits only for addr_done
    gdma_addr_done = 1'b0;
    start_op(32'd3, 1'b0);
    tick();
    tick();
    tick();
    check("zero_done_wait", gdma_done, 0);
    gdma_addr_done = 1'b1;
    wait_done("zero_done", 5);
    check("zero_no_out", out_cnt, 0);

    // Reset mid-packet aborts output
    start_op(32'd64, 1'b0);
    for (int i = 0; i < 16; i++) begin
      src_data.push_back(32'h7700_0000 + 32'(i)); src_resp.push_back(2'b00);
    end
    build_pkg(16);
    tick();
    run_until_out("abort_partial", 2, 50);
    #2 rst = 1'b1;
    #1;
    check("abort_tvalid", bus.gdma2gtp_tvalid, 0);
    check("abort_done",   gdma_done, 1);
    check("abort_rready", bus.gdma_ddr_rready, 0);
    tick();
    rst = 1'b0;
    prev_stall = 0;
    repeat (10) tick();
    check("abort_no_more", out_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/north_rdata_pkt.md
NORTH_RDATA_PKT -- requirements
Module: north_rdata_pkt

Interface
REQ-001 SHALL have parameter DATA_W, default 32, read/stream data width; legal values 32, 64, 128.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, package-path buffer depth in beats; power of 2, at least 4.
REQ-003 SHALL have parameter PKT_BEATS, default 64, maximum payload beats per packet; at least 1 and below 2^24.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- length  in  32  transfer size in bytes.
- op_start  in  1  one-cycle start pulse.
- gdma_addr_done  in  1  address side finished.
- gdma_done  out  1  transfer complete/idle.
- gdma_speed_divider  in  32  inter-packet gap in cycles.
- gdma_package_bypass  in  1  bypass mode request.
- extern_spike  in  1  forces bypass.
- gdma_ddr_rdata  in  DATA_W  read data.
- gdma_ddr_rlast  in  1  burst last (ignored).
- gdma_ddr_rresp  in  2  read response.
- gdma_ddr_rvalid  in  1  read valid.
- gdma_ddr_rready  out  1  read ready.
- gdma2gtp_tdata  out  DATA_W  stream data.
- gdma2gtp_tvalid  out  1  stream valid.
- gdma2gtp_tready  in  1  stream ready.
- gdma2gtp_tlast  out  1  last beat of packet.
- resp_err  out  1  sticky read-error flag.

Function
REQ-005 SHALL compute BEATS = length >> log2(DATA_W/8) at op_start; any remainder bytes SHALL be ignored.
REQ-006 SHALL latch mode at op_start as byp_q = gdma_package_bypass | extern_spike; later input changes SHALL NOT affect the operation in progress.
REQ-007 SHALL count accepted beats (rvalid & rready); beats beyond BEATS SHALL be accepted and dropped, not forwarded.
REQ-008 Bypass mode SHALL connect rdata to tdata, rvalid to tvalid (for beats not beyond BEATS), and tready to rready combinationally, with zero latency; tlast SHALL be driven 0.
REQ-009 Package mode SHALL write accepted beats into the FIFO; rready SHALL equal !fifo_full; no beat SHALL be lost or duplicated.
REQ-010 Package FSM SHALL have states IDLE, HEAD, PAY, GAP; reset and op_start SHALL both go to IDLE.
REQ-011 IDLE->HEAD SHALL occur when remaining beats > 0 and the FIFO is non-empty.
REQ-012 In HEAD, the block SHALL present header tdata = {8'hA5, zeros, n[23:0]}, where n = min(remaining, PKT_BEATS) and tlast = 0; on tready it SHALL go to PAY.
REQ-013 PAY SHALL stream n beats from the FIFO, with tvalid = !fifo_empty and tlast = 1 on the nth beat; after the nth handshake it SHALL go to GAP.
REQ-014 GAP SHALL hold tvalid = 0 for gdma_speed_divider cycles (0 means zero cycles), then go to IDLE.
REQ-015 The remaining-beat counter SHALL decrement per PAY handshake.
REQ-016 gdma_done SHALL fall on op_start; it SHALL rise when gdma_addr_done = 1, all BEATS have been accepted, and (bypass, or FIFO empty and FSM in IDLE with remaining = 0).
REQ-017 BEATS = 0 SHALL make gdma_done rise once gdma_addr_done = 1, with no output beats.
REQ-018 resp_err SHALL set on any accepted beat with rresp != 0, and SHALL clear on op_start.
REQ-019 op_start while busy SHALL flush the FIFO, reset the counters and FSM, and restart with the new length and mode; op_start has priority over a same-cycle handshake.
REQ-020 tdata/tvalid/tlast SHALL be held stable while tvalid = 1 and tready = 0.

Reset
REQ-021 rst SHALL force gdma_done = 1, resp_err = 0, tvalid = 0, tlast = 0, FSM = IDLE, FIFO empty, counters = 0, byp_q = 0.
REQ-022 With no operation started, rready SHALL be 0 in package mode, and SHALL equal tready in bypass mode (beats dropped).
REQ-023 rst asserted mid-operation SHALL abort immediately, with no further output beats.

Verification
REQ-024 Bypass, DATA_W = 32, length = 16, tready = 1 -> 4 beats pass with zero latency; gdma_done rises the cycle after the 4th beat with addr_done = 1.
REQ-025 Package, PKT_BEATS = 4, length = 40 (10 beats) -> headers n = 4, 4, 2; tlast on payload beats 4, 8, 10; 13 output beats total.
REQ-026 Package, gdma_speed_divider = 5 -> exactly 5 idle cycles between a packet's tlast and the next header.
REQ-027 Random tready with 50% duty and FIFO_DEPTH = 4 -> rready drops when full, the output data sequence equals the input, and tdata stays stable under backpressure.
REQ-028 Beat 3 with rresp = 2'b10 -> resp_err = 1 until the next op_start; op_start mid-packet -> FIFO flushed, new header with the new n.
